// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32 pipeline: datapath width, ALU operation codes and
// execute-stage FSM encoding.
package rv_pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_MUL   = 4'd10;
    localparam logic [3:0] ALU_MULHU = 4'd11;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StMul  = 1'b1
    } ex_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU);
    endfunction

endpackage

// File: rtl/ex_stage_unit_if.sv
// ID/EX input bundle and EX/MEM result bundle of the execute stage, with the stall back to decode.
interface ex_stage_unit_if #(
    parameter int unsigned XLEN = rv_pipe_pkg::XLEN
) ();

    logic            in_valid;
    logic            flush;
    logic            regwrite_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic [4:0]      rd_i;
    logic [3:0]      aluctrl_i;

    logic            stall_o;
    logic            out_valid;
    logic            regwrite_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output in_valid, flush, regwrite_i, data1_i, data2_i, rd_i, aluctrl_i,
        input  stall_o, out_valid, regwrite_o, result_o, rd_o
    );

    modport slave (
        input  in_valid, flush, regwrite_i, data1_i, data2_i, rd_i, aluctrl_i,
        output stall_o, out_valid, regwrite_o, result_o, rd_o
    );

endinterface

// File: rtl/mul_iter_unsigned.sv
// Iterative unsigned shift-add multiplier: one partial product per step, LSB of the multiplier first.
module mul_iter_unsigned #(
    parameter int unsigned Width  = 32,
    parameter int unsigned Cycles = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               step_i,
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    output logic               done_o,
    output logic [2*Width-1:0] product_o
);

    localparam int unsigned CntW = $clog2(Cycles);

    logic [Width-1:0]   a_q, a_d;
    logic [Width-1:0]   b_q, b_d;
    logic [2*Width-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*Width-1:0] addend;

    always_comb begin
        addend = b_q[cnt_q] ? ({{Width{1'b0}}, a_q} << cnt_q) : '0;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = '0;
            cnt_d = '0;
        end else if (step_i) begin
            acc_d = acc_q + addend;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Product includes the final step's addend so it is usable on the completing edge.
    assign product_o = acc_q + addend;
    assign done_o    = step_i && (cnt_q == CntW'(Cycles - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_stage_unit.sv
// RV32 execute stage: single-cycle ALU plus iterative unsigned multiply, stalling decode while
// the multiply runs, with a registered result bundle toward EX/MEM.
module ex_stage_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input logic            clk,
    input logic            rst,
    ex_stage_unit_if.slave bus
);

    import rv_pipe_pkg::*;

    ex_state_e       state_q, state_d;
    logic            valid_q, valid_d;
    logic            regwrite_q, regwrite_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            mul_hi_q, mul_hi_d;
    logic            mul_rw_q, mul_rw_d;
    logic [4:0]      mul_rd_q, mul_rd_d;

    logic            accept;
    logic            mul_start;
    logic            mul_step;
    logic            mul_done;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;

    assign accept    = bus.in_valid && (state_q == StIdle) && !bus.flush;
    assign mul_start = accept && is_mul_op(bus.aluctrl_i);
    // A flushed step is not taken; the next start clears the unit anyway.
    assign mul_step  = (state_q == StMul) && !bus.flush;
    assign shamt     = bus.data2_i[4:0];

    always_comb begin
        alu_res = '0;
        unique case (bus.aluctrl_i)
            ALU_ADD:  alu_res = bus.data1_i + bus.data2_i;
            ALU_SUB:  alu_res = bus.data1_i - bus.data2_i;
            ALU_AND:  alu_res = bus.data1_i & bus.data2_i;
            ALU_OR:   alu_res = bus.data1_i | bus.data2_i;
            ALU_XOR:  alu_res = bus.data1_i ^ bus.data2_i;
            ALU_SLL:  alu_res = bus.data1_i << shamt;
            ALU_SRL:  alu_res = bus.data1_i >> shamt;
            ALU_SRA:  alu_res = $signed(bus.data1_i) >>> shamt;
            ALU_SLT:  alu_res[0] = $signed(bus.data1_i) < $signed(bus.data2_i);
            ALU_SLTU: alu_res[0] = bus.data1_i < bus.data2_i;
            default:  alu_res = '0;
        endcase
    end

    mul_iter_unsigned #(
        .Width  (XLEN),
        .Cycles (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .a_i       (bus.data1_i),
        .b_i       (bus.data2_i),
        .done_o    (mul_done),
        .product_o (product)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        regwrite_d = 1'b0;
        result_d   = result_q;
        rd_d       = rd_q;
        mul_hi_d   = mul_hi_q;
        mul_rw_d   = mul_rw_q;
        mul_rd_d   = mul_rd_q;
        unique case (state_q)
            StIdle: begin
                if (mul_start) begin
                    state_d  = StMul;
                    mul_hi_d = (bus.aluctrl_i == ALU_MULHU);
                    mul_rw_d = bus.regwrite_i;
                    mul_rd_d = bus.rd_i;
                end else if (accept) begin
                    valid_d    = 1'b1;
                    regwrite_d = bus.regwrite_i;
                    result_d   = alu_res;
                    rd_d       = bus.rd_i;
                end
            end
            StMul: begin
                // Flush wins over completion of the final step.
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (mul_done) begin
                    state_d    = StIdle;
                    valid_d    = 1'b1;
                    regwrite_d = mul_rw_q;
                    result_d   = mul_hi_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
                    rd_d       = mul_rd_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            result_q   <= '0;
            rd_q       <= '0;
            mul_hi_q   <= 1'b0;
            mul_rw_q   <= 1'b0;
            mul_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
            mul_hi_q   <= mul_hi_d;
            mul_rw_q   <= mul_rw_d;
            mul_rd_q   <= mul_rd_d;
        end
    end

    assign bus.stall_o    = (state_q == StMul);
    assign bus.out_valid  = valid_q;
    assign bus.regwrite_o = regwrite_q;
    assign bus.result_o   = result_q;
    assign bus.rd_o       = rd_q;

endmodule
